uart_tx_arbiter: RTL and testbench

//  Shares the single SoC UART transmitter between NUM_REQ byte-stream requesters
//  (CPU peripheral path, boot ROM, debug/trace). Packet-locked round-robin arbitration.

---
 rtl/uart_tx_arbiter.sv | 267 ++++++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Purpose : packet-locked round-robin arbiter sharing one uart_tx byte port between NUM_REQ requesters.
// Latency : an accepted requester byte appears on tx_data_o one cycle later; a new grant costs one IDLE cycle.
// Backpressure: tx_ready_i low stalls the output register; req_ready_o of the owner drops until it drains.
//
// Optional feature macro: UART_ARB_TAG_EN
//   defined   -> every packet is preceded by a tag byte TAG_BASE+owner index (extra TAG state).
//   undefined -> payload bytes only; TAG_BASE is not used.
//
// Ports
//   clk_i        system clock
//   reset_ni     synchronous active-low reset
//   req_valid_i  per-requester byte valid
//   req_data_i   per-requester byte, requester i at [8*i+:8]
//   req_last_i   byte is the last of its packet
//   req_ready_o  per-requester accept, only the owner's bit can be set
//   tx_valid_o   byte valid toward uart_tx (registered)
//   tx_data_o    byte toward uart_tx (registered)
//   tx_ready_i   uart_tx accepts the byte
//   grant_o      one-hot current owner, 0 while idle
//   busy_o       arbiter owned or output register still holds a byte
//   timeout_o    one-cycle pulse when a stalled owner is forcibly released

module uart_tx_arbiter #(
    parameter int         NUM_REQ      = 4,
    parameter int         LOCK_TIMEOUT = 1024,
    parameter logic [7:0] TAG_BASE     = 8'h41
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 tx_valid_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_ready_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    localparam int             IW      = $clog2(NUM_REQ);
    localparam int             CW      = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [IW-1:0]  LastIdx = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0]  CntMax  = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TAG  = 2'd1,
        S_XFER = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        rr_q, rr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 tx_vld_q, tx_vld_d;
    logic [7:0]           tx_dat_q, tx_dat_d;

    // Output register can take a new byte when empty or being consumed this cycle.
    logic out_free;
    assign out_free = ~tx_vld_q | tx_ready_i;

    // ------------------------------------------------------------------
    // Owner's request signals, muxed by the stored grant index.
    // ------------------------------------------------------------------
    logic       sel_vld;
    logic       sel_last;
    logic [7:0] sel_dat;

    always_comb begin
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_dat  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx_q == IW'(i)) begin
                sel_vld  = req_valid_i[i];
                sel_last = req_last_i[i];
                sel_dat  = req_data_i[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first valid requester at or after rr_q, wrapping.
    // ------------------------------------------------------------------
    logic          pick_vld;
    logic [IW-1:0] pick_idx;

    always_comb begin
        int cand;
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!pick_vld && req_valid_i[IW'(cand)]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(cand);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    logic accept;        // owner byte taken into the output register
    logic tag_load;      // tag byte taken into the output register
    logic timeout_fire;  // stalled owner released this cycle
    logic release_own;   // ownership ends this cycle

    always_comb begin
        accept       = 1'b0;
        tag_load     = 1'b0;
        timeout_fire = 1'b0;
        req_ready_o  = '0;
        case (state_q)
            S_XFER: begin
                if (out_free) begin
                    req_ready_o = grant_q;
                end
                accept = sel_vld & out_free;
                // Only an absent owner byte counts as idle; a stalled uart never does.
                timeout_fire = ~sel_vld & (cnt_q == CntMax);
            end
`ifdef UART_ARB_TAG_EN
            S_TAG: begin
                tag_load = out_free;
            end
`endif
            default: begin
            end
        endcase
    end

    assign release_own = (accept & sel_last) | timeout_fire;

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
`ifdef UART_ARB_TAG_EN
                    state_d = S_TAG;
`else
                    state_d = S_XFER;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            S_TAG: begin
                if (out_free) begin
                    state_d = S_XFER;
                end
            end
`endif
            S_XFER: begin
                if (release_own) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next state: grant, RR pointer, lock timer, output register
    // ------------------------------------------------------------------
`ifdef UART_ARB_TAG_EN
    logic [7:0] tag_byte;
    assign tag_byte = TAG_BASE + 8'(gidx_q);
`else
    logic [7:0] unused_tag_base;
    assign unused_tag_base = TAG_BASE;
`endif

    always_comb begin
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        tx_vld_d = tx_vld_q;
        tx_dat_d = tx_dat_q;

        if (state_q == S_IDLE && pick_vld) begin
            grant_d = NUM_REQ'(1) << pick_idx;
            gidx_d  = pick_idx;
            cnt_d   = '0;
        end

        if (state_q == S_XFER) begin
            if (accept) begin
                cnt_d = '0;
            end else if (!sel_vld) begin
                cnt_d = cnt_q + CW'(1);
            end
            if (release_own) begin
                grant_d = '0;
                rr_d    = (gidx_q == LastIdx) ? '0 : gidx_q + IW'(1);
                cnt_d   = '0;
            end
        end

        // Drain first, then a load in the same cycle overrides it.
        if (tx_ready_i) begin
            tx_vld_d = 1'b0;
        end
        if (accept) begin
            tx_vld_d = 1'b1;
            tx_dat_d = sel_dat;
        end
`ifdef UART_ARB_TAG_EN
        else if (tag_load) begin
            tx_vld_d = 1'b1;
            tx_dat_d = tag_byte;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
            tx_vld_q <= 1'b0;
            tx_dat_q <= 8'h00;
        end else begin
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            tx_vld_q <= tx_vld_d;
            tx_dat_q <= tx_dat_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx_valid_o = tx_vld_q;
    assign tx_data_o  = tx_dat_q;
    assign grant_o    = grant_q;
    assign busy_o     = (state_q != S_IDLE) | tx_vld_q;
    assign timeout_o  = timeout_fire;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose : self-checking bench for uart_tx_arbiter against a packet-level round-robin model.
// Latency : n/a (bench).
// Backpressure: tx_ready_i driven randomly or held low in scripted stalls.

module tb_uart_tx_arbiter;

    localparam int         N     = 4;
    localparam int         LT    = 16;
    localparam logic [7:0] TAG_B = 8'h41;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N-1:0]     req_valid;
    logic [N*8-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready;
    logic [N-1:0]     grant;
    logic             busy;
    logic             timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .LOCK_TIMEOUT (LT),
        .TAG_BASE     (TAG_B)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (tx_ready),
        .grant_o     (grant),
        .busy_o      (busy),
        .timeout_o   (timeout)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  bq [N][$];     // pending bytes per requester
    bit          lq [N][$];     // matching last flags
    logic [7:0]  expq [$];      // expected uart byte stream
    int          txt [$];       // iteration index of each uart handshake
    int          rr_model = 0;  // model's round-robin pointer

    task automatic add_byte(input int r, input logic [7:0] b, input bit last);
        bq[r].push_back(b);
        lq[r].push_back(last);
    endtask

    task automatic add_rand_pkt(input int r, input int len);
        for (int k = 0; k < len; k++) begin
            add_byte(r, 8'($urandom_range(0, 255)), k == len - 1);
        end
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            bq[i].delete();
            lq[i].delete();
        end
        expq.delete();
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (bq[i].size() > 0) begin
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = bq[i][0];
                req_last[i]       = lq[i][0];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    task automatic pop_accepts();
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                void'(bq[i].pop_front());
                void'(lq[i].pop_front());
            end
        end
    endtask

    // Packet-level model: every requester with queued packets keeps valid high,
    // so packets leave in round-robin order starting at the pointer; each packet
    // moves the pointer just past its owner.
    task automatic build_expected();
        int rd [N];
        int p;
        int g;
        for (int i = 0; i < N; i++) rd[i] = 0;
        p = rr_model;
        forever begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                int i;
                i = (p + k) % N;
                if (g < 0 && rd[i] < bq[i].size()) g = i;
            end
            if (g < 0) break;
`ifdef UART_ARB_TAG_EN
            expq.push_back(TAG_B + 8'(g));
`endif
            expq.push_back(bq[g][rd[g]]);
            rd[g]++;
            while (rd[g] < bq[g].size() && !lq[g][rd[g] - 1]) begin
                expq.push_back(bq[g][rd[g]]);
                rd[g]++;
            end
            p = (g + 1) % N;
        end
        rr_model = p;
    endtask

    // Drives the queued traffic and checks the uart stream against expq.
    // stall_at >= 0: after that many uart bytes, hold tx_ready low stall_len cycles.
    task automatic run_traffic(input string name, input int budget, input int ready_pct,
                               input int stall_at, input int stall_len);
        int         viol = 0;
        int         c = 0;
        int         txcount = 0;
        int         stall_left;
        bit         done = 0;
        bit         stalled;
        bit         holding = 0;
        logic [7:0] held = 8'h00;
        stall_left = stall_len;
        txt.delete();
        while (!done && c < budget) begin
            @(negedge clk);
            drive_inputs();
            stalled = (stall_at >= 0) && (txcount == stall_at) && (stall_left > 0);
            if (stalled) begin
                tx_ready = 1'b0;
                stall_left--;
            end else begin
                tx_ready = ($urandom_range(0, 99) < ready_pct);
            end
            #1;
            if (((req_ready & ~grant) != '0) || ($countones(grant) > 1) || timeout) viol++;
            if (stalled) begin
                if (!holding) begin
                    holding = 1;
                    held    = tx_data;
                    n_tests++;
                    if (tx_valid !== 1'b1 || expq.size() == 0 || tx_data !== expq[0]) begin
                        n_fail++;
                        $display("FAIL %s_stall_pending: valid=%b data=%h want valid=1 data=%h",
                                 name, tx_valid, tx_data, (expq.size() > 0) ? expq[0] : 8'hxx);
                    end
                end
                n_tests++;
                if (tx_valid !== 1'b1 || tx_data !== held || req_ready !== '0 || timeout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_stall_hold: valid=%b data=%h ready=%b timeout=%b want 1 %h 0000 0",
                             name, tx_valid, tx_data, req_ready, timeout, held);
                end
            end
            if (tx_valid && tx_ready) begin
                n_tests++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_extra_byte: got %h want none", name, tx_data);
                end else begin
                    if (tx_data !== expq[0]) begin
                        n_fail++;
                        $display("FAIL %s_byte%0d: got %h want %h", name, txcount, tx_data, expq[0]);
                    end
                    void'(expq.pop_front());
                end
                txt.push_back(c);
                txcount++;
            end
            pop_accepts();
            c++;
            done = (expq.size() == 0);
            for (int i = 0; i < N; i++) if (bq[i].size() != 0) done = 0;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_complete: %0d bytes outstanding after %0d cycles, want 0", name, expq.size(), c);
        end
        n_tests++;
        if (viol != 0) begin
            n_fail++;
            $display("FAIL %s_invariants: %0d violating cycles, want 0", name, viol);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        tx_ready = 1'b0;
        clear_queues();
        drive_inputs();
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if ({tx_valid, grant, req_ready, busy, timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b grant=%b ready=%b busy=%b timeout=%b want all 0",
                     tx_valid, grant, req_ready, busy, timeout);
        end
        @(negedge clk);
        reset_n = 1'b1;
        add_byte(0, 8'h11, 0);
        add_byte(0, 8'h22, 0);
        add_byte(0, 8'h33, 1);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            drive_inputs();
            tx_ready = 1'b0;
            #1;
            pop_accepts();
        end
        n_tests++;
        if (grant !== 4'b0001 || tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midpkt_setup: grant=%b valid=%b want 0001 1", grant, tx_valid);
        end
        @(negedge clk);
        reset_n = 1'b0;
        drive_inputs();
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if ({tx_valid, grant, req_ready, busy, timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_midpkt: valid=%b grant=%b ready=%b busy=%b want all 0",
                     tx_valid, grant, req_ready, busy);
        end
        clear_queues();
        drive_inputs();
        reset_n  = 1'b1;
        rr_model = 0;
        @(negedge clk);
        #1;
        n_tests++;
        if ({tx_valid, grant, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b grant=%b busy=%b want all 0", tx_valid, grant, busy);
        end
    endtask

    task automatic test_single();
        int nb;
        add_byte(0, 8'h48, 0);
        add_byte(0, 8'h69, 0);
        add_byte(0, 8'h0A, 1);
        build_expected();
        nb = expq.size();
        run_traffic("single", 200, 100, -1, 0);
        n_tests++;
        if (txt.size() != nb || txt[txt.size() - 1] - txt[0] != nb - 1) begin
            n_fail++;
            $display("FAIL single_back_to_back: %0d bytes over span %0d want %0d over %0d",
                     txt.size(), (txt.size() > 0) ? txt[txt.size() - 1] - txt[0] : -1, nb, nb - 1);
        end
        @(negedge clk);
        drive_inputs();
        #1;
        n_tests++;
        if (grant !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: grant=%b busy=%b want 0000 0", grant, busy);
        end
    endtask

    task automatic test_rr();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        rr_model = 0;
        add_rand_pkt(0, 3);
        add_rand_pkt(2, 2);
        build_expected();
        run_traffic("rr_first", 300, 100, -1, 0);
        add_rand_pkt(1, 2);
        add_rand_pkt(0, 3);
        build_expected();
        run_traffic("rr_second", 300, 100, -1, 0);
    endtask

    task automatic test_backpressure();
        add_rand_pkt(3, 6);
        build_expected();
        run_traffic("bp", 300, 100, 2, 20);
    endtask

    task automatic test_timeout();
        int acc_c = -1;
        int to_c  = -1;
        int to_n  = 0;
        add_byte(1, 8'hA1, 0);
        add_byte(1, 8'hA2, 0);
`ifdef UART_ARB_TAG_EN
        expq.push_back(8'h42);
`endif
        expq.push_back(8'hA1);
        expq.push_back(8'hA2);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            drive_inputs();
            tx_ready = 1'b1;
            #1;
            if (timeout === 1'b1) begin
                to_n++;
                if (to_c < 0) to_c = c;
            end
            if (to_c >= 0 && c == to_c + 1) begin
                n_tests++;
                if (grant !== '0 || timeout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_release: grant=%b timeout=%b want 0000 0", grant, timeout);
                end
            end
            if (tx_valid && tx_ready) begin
                n_tests++;
                if (expq.size() == 0 || tx_data !== expq[0]) begin
                    n_fail++;
                    $display("FAIL timeout_byte: got %h want %h", tx_data, (expq.size() > 0) ? expq[0] : 8'hxx);
                end
                if (expq.size() > 0) void'(expq.pop_front());
            end
            if (req_valid[1] && req_ready[1] && bq[1].size() == 1) acc_c = c;
            pop_accepts();
        end
        n_tests++;
        if (to_n != 1 || acc_c < 0 || to_c - acc_c != LT) begin
            n_fail++;
            $display("FAIL timeout_pulse: pulses=%0d delay=%0d want 1 pulse delay %0d",
                     to_n, to_c - acc_c, LT);
        end
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_drain: %0d bytes left want 0", expq.size());
        end
        expq.delete();
        rr_model = 2;
    endtask

    task automatic test_tag();
        add_byte(2, 8'h58, 1);
`ifdef UART_ARB_TAG_EN
        expq.push_back(8'h43);
`endif
        expq.push_back(8'h58);
        rr_model = 3;
        run_traffic("tag", 100, 100, -1, 0);
    endtask

    task automatic test_random();
        for (int round = 0; round < 6; round++) begin
            int mask;
            mask = $urandom_range(1, (1 << N) - 1);
            for (int r = 0; r < N; r++) begin
                if (mask[r]) begin
                    int npk;
                    npk = $urandom_range(1, 3);
                    for (int p = 0; p < npk; p++) add_rand_pkt(r, $urandom_range(1, 6));
                end
            end
            build_expected();
            run_traffic("random", 3000, 70, -1, 0);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
        test_reset();
        test_single();
        test_rr();
        test_backpressure();
        test_timeout();
        test_tag();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
